// File: rtl/priv_1_12_debug_mode_ctrl_pkg.sv
// Shared types and constants for the RISC-V debug-mode controller.
// Holds the controller state enum, the dcsr halt-cause encoding, the
// packed dcsr layout, and the CSR addresses and masks the controller
// decodes.
// No ports: this is a package.
package debug_types_1_12_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        RESUME = 2'd3
    } dbg_state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE = 3'd0,
        EBREAK     = 3'd1,
        HALTREQ    = 3'd3,
        STEP       = 3'd4
    } dbg_cause_t;

    typedef struct packed {
        logic [3:0]  xdebugver;
        logic [11:0] zero_27_16;
        logic        ebreakm;
        logic [5:0]  zero_14_9;
        dbg_cause_t  cause;
        logic [2:0]  zero_5_3;
        logic        step;
        logic [1:0]  prv;
    } dcsr_t;

    localparam logic [11:0] DCSR_ADDR = 12'h7B0;
    localparam logic [11:0] DPC_ADDR  = 12'h7B1;

    // dcsr comes out of reset with xdebugver=4 and prv=M
    localparam logic [31:0] DCSR_RESET = 32'h4000_0003;

    // Only ebreakm, step and prv are software-writable
    localparam logic [31:0] DCSR_WMASK = 32'h0000_8007;

    localparam logic [1:0] PRIV_M = 2'b11;

endpackage

// File: rtl/priv_1_12_debug_mode_ctrl_if.sv
// Bundle of the core-side signals of the debug-mode controller.
// master: the core pipeline / debug module side (drives requests, commit
//         information and CSR accesses; receives redirects and status).
// slave:  the debug-mode controller itself.
// Signals:
//   haltreq, resumereq           requests from the debug module
//   insn_commit, ebreak_commit,
//   dret_commit                  commit-stage events
//   commit_pc, commit_npc        PC of the committing instruction / next PC
//   pipe_clear                   pipeline has drained
//   curr_priv                    current privilege level
//   csr_wen, csr_addr, csr_wdata CSR write port, csr_rdata read data
//   halt_pipe, dmode, halted,
//   resumeack                    controller status
//   redirect_valid, redirect_pc,
//   restore_priv                 fetch redirect and privilege to restore
interface priv_1_12_debug_mode_ctrl_if;
    logic        haltreq;
    logic        resumereq;
    logic        insn_commit;
    logic        ebreak_commit;
    logic        dret_commit;
    logic [31:0] commit_pc;
    logic [31:0] commit_npc;
    logic        pipe_clear;
    logic [1:0]  curr_priv;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        halt_pipe;
    logic        dmode;
    logic        halted;
    logic        resumeack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  restore_priv;

    modport master (
        output haltreq, resumereq, insn_commit, ebreak_commit, dret_commit,
        output commit_pc, commit_npc, pipe_clear, curr_priv,
        output csr_wen, csr_addr, csr_wdata,
        input  csr_rdata, halt_pipe, dmode, halted, resumeack,
        input  redirect_valid, redirect_pc, restore_priv
    );

    modport slave (
        input  haltreq, resumereq, insn_commit, ebreak_commit, dret_commit,
        input  commit_pc, commit_npc, pipe_clear, curr_priv,
        input  csr_wen, csr_addr, csr_wdata,
        output csr_rdata, halt_pipe, dmode, halted, resumeack,
        output redirect_valid, redirect_pc, restore_priv
    );
endinterface

// File: rtl/priv_1_12_debug_mode_ctrl.sv
// RISC-V debug-mode entry/exit controller.
// Watches the commit stage for halt triggers (ebreak in M-mode with
// dcsr.ebreakm, a debug-module halt request, or a single-step), freezes the
// pipeline, redirects fetch into the debug ROM, and on dret/resume request
// redirects back to dpc with the saved privilege. Owns dcsr and dpc.
// Ports:
//   CLK   rising-edge clock
//   nRST  synchronous active-low reset
//   dbg   core-side signal bundle (slave modport)
// Parameter:
//   DEBUG_ENTRY_ADDR  debug ROM entry PC
module priv_1_12_debug_mode_ctrl
    import debug_types_1_12_pkg::*;
#(
    parameter logic [31:0] DEBUG_ENTRY_ADDR = 32'h0000_0800
) (
    input logic                         CLK,
    input logic                         nRST,
    priv_1_12_debug_mode_ctrl_if.slave  dbg
);

    dbg_state_t  state;
    dcsr_t       dcsr;
    logic [31:0] dpc;
    logic        step_armed;
    logic        halt_pending;

    logic        halt_pipe_q;
    logic        dmode_q;
    logic        halted_q;
    logic        resumeack_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;
    logic [1:0]  restore_priv_q;

    dcsr_t       dcsr_wr;
    logic [31:0] dpc_wr;
    logic        ebreak_hit;
    logic        halt_hit;
    logic        step_hit;

    // CSR writes only land while in debug mode. dcsr_wr/dpc_wr are the
    // post-write values so a resume in the same cycle sees the new contents.
    always_comb begin
        dcsr_wr = dcsr;
        dpc_wr  = dpc;
        if (dmode_q && dbg.csr_wen) begin
            if (dbg.csr_addr == DCSR_ADDR) begin
                dcsr_wr = dcsr_t'((dbg.csr_wdata & DCSR_WMASK) | (dcsr & ~DCSR_WMASK));
            end
            if (dbg.csr_addr == DPC_ADDR) begin
                dpc_wr = dbg.csr_wdata & ~32'h3;
            end
        end
    end

    // Entry triggers, evaluated only while running
    always_comb begin
        ebreak_hit = dbg.ebreak_commit && dcsr.ebreakm && (dbg.curr_priv == PRIV_M);
        halt_hit   = (dbg.haltreq || halt_pending) && dbg.insn_commit;
        step_hit   = step_armed && dbg.insn_commit;
    end

    // CSR read mux: the only combinational input-to-output path
    always_comb begin
        dbg.csr_rdata = '0;
        if (dmode_q) begin
            if (dbg.csr_addr == DCSR_ADDR) begin
                dbg.csr_rdata = dcsr;
            end else if (dbg.csr_addr == DPC_ADDR) begin
                dbg.csr_rdata = dpc;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state            <= RUN;
            dcsr             <= dcsr_t'(DCSR_RESET);
            dpc              <= '0;
            step_armed       <= 1'b0;
            halt_pending     <= 1'b0;
            halt_pipe_q      <= 1'b0;
            dmode_q          <= 1'b0;
            halted_q         <= 1'b0;
            resumeack_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            restore_priv_q   <= 2'b11;
        end else begin
            dcsr             <= dcsr_wr;
            dpc              <= dpc_wr;
            redirect_valid_q <= 1'b0;
            resumeack_q      <= 1'b0;
            case (state)
                RUN: begin
                    if (ebreak_hit || halt_hit || step_hit) begin
                        state        <= DRAIN;
                        halt_pipe_q  <= 1'b1;
                        step_armed   <= 1'b0;
                        halt_pending <= 1'b0;
                        dcsr.prv     <= dbg.curr_priv;
                        // ebreak re-executes from its own PC; halts and steps
                        // resume at the instruction after the one that retired
                        if (ebreak_hit) begin
                            dcsr.cause <= EBREAK;
                            dpc        <= dbg.commit_pc;
                        end else if (halt_hit) begin
                            dcsr.cause <= HALTREQ;
                            dpc        <= dbg.commit_npc;
                        end else begin
                            dcsr.cause <= STEP;
                            dpc        <= dbg.commit_npc;
                        end
                    end else if (dbg.haltreq) begin
                        halt_pending <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (dbg.pipe_clear) begin
                        state            <= HALTED;
                        dmode_q          <= 1'b1;
                        halted_q         <= 1'b1;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= DEBUG_ENTRY_ADDR;
                    end
                end
                HALTED: begin
                    // dret and resumereq lead to the same resume sequence
                    if (dbg.dret_commit || dbg.resumereq) begin
                        state            <= RESUME;
                        halted_q         <= 1'b0;
                        halt_pipe_q      <= 1'b0;
                        resumeack_q      <= 1'b1;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= dpc_wr;
                        restore_priv_q   <= dcsr_wr.prv;
                    end else if (dbg.ebreak_commit) begin
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= DEBUG_ENTRY_ADDR;
                    end
                end
                RESUME: begin
                    state      <= RUN;
                    dmode_q    <= 1'b0;
                    step_armed <= dcsr_wr.step;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign dbg.halt_pipe      = halt_pipe_q;
    assign dbg.dmode          = dmode_q;
    assign dbg.halted         = halted_q;
    assign dbg.resumeack      = resumeack_q;
    assign dbg.redirect_valid = redirect_valid_q;
    assign dbg.redirect_pc    = redirect_pc_q;
    assign dbg.restore_priv   = restore_priv_q;

endmodule

// File: tb/tb_priv_1_12_debug_mode_ctrl.sv
// Testbench for priv_1_12_debug_mode_ctrl.
// Each vector drives one cycle of inputs; its expected post-edge outputs are
// pushed to a scoreboard queue and popped when the outputs are sampled.
module tb_priv_1_12_debug_mode_ctrl;

    typedef struct packed {
        logic        haltreq;
        logic        resumereq;
        logic        insn_commit;
        logic        ebreak_commit;
        logic        dret_commit;
        logic        pipe_clear;
        logic [1:0]  curr_priv;
        logic [31:0] commit_pc;
        logic [31:0] commit_npc;
        logic        csr_wen;
        logic [11:0] csr_addr;
        logic [31:0] csr_wdata;
    } in_t;

    typedef struct packed {
        logic [4:0]  flags;
        logic [31:0] redirect_pc;
        logic [1:0]  restore_priv;
        logic [31:0] csr_rdata;
    } exp_t;

    typedef struct {
        in_t  stim;
        exp_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic nrst;
    vec_t vec_q[$];
    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    int   step_no = 0;

    priv_1_12_debug_mode_ctrl_if dbg_if ();

    priv_1_12_debug_mode_ctrl #(
        .DEBUG_ENTRY_ADDR(32'h0000_0800)
    ) dut (
        .CLK  (clk),
        .nRST (nrst),
        .dbg  (dbg_if)
    );

    always #5 clk = ~clk;

    // ctl = {haltreq, resumereq, insn_commit, ebreak_commit, dret_commit, pipe_clear}
    // flags = {halt_pipe, dmode, halted, resumeack, redirect_valid}
    function automatic vec_t mk(input logic [5:0] ctl, input logic [1:0] priv,
                                input logic [31:0] cpc, input logic [31:0] npc,
                                input logic wen, input logic [11:0] addr,
                                input logic [31:0] wdata, input logic [4:0] flags,
                                input logic [31:0] rpc, input logic [1:0] rprv,
                                input logic [31:0] rdata);
        vec_t v;
        v.stim.haltreq       = ctl[5];
        v.stim.resumereq     = ctl[4];
        v.stim.insn_commit   = ctl[3];
        v.stim.ebreak_commit = ctl[2];
        v.stim.dret_commit   = ctl[1];
        v.stim.pipe_clear    = ctl[0];
        v.stim.curr_priv     = priv;
        v.stim.commit_pc     = cpc;
        v.stim.commit_npc    = npc;
        v.stim.csr_wen       = wen;
        v.stim.csr_addr      = addr;
        v.stim.csr_wdata     = wdata;
        v.exp.flags          = flags;
        v.exp.redirect_pc    = rpc;
        v.exp.restore_priv   = rprv;
        v.exp.csr_rdata      = rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s (vector %0d): got %0h, expected %0h", name, step_no, act, req);
        end
    endtask

    task automatic check_output();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            $display("[TB] FAIL scoreboard (vector %0d): got empty queue, expected an entry", step_no);
            return;
        end
        e = sb_q.pop_front();
        check("status", {57'd0, dbg_if.halt_pipe, dbg_if.dmode, dbg_if.halted,
                         dbg_if.resumeack, dbg_if.redirect_valid, dbg_if.restore_priv},
              {57'd0, e.flags, e.restore_priv});
        if (e.flags[0]) begin
            check("redirect_pc", {32'd0, dbg_if.redirect_pc}, {32'd0, e.redirect_pc});
        end
        check("csr_rdata", {32'd0, dbg_if.csr_rdata}, {32'd0, e.csr_rdata});
    endtask

    task automatic apply_stimulus(input vec_t v);
        dbg_if.haltreq       = v.stim.haltreq;
        dbg_if.resumereq     = v.stim.resumereq;
        dbg_if.insn_commit   = v.stim.insn_commit;
        dbg_if.ebreak_commit = v.stim.ebreak_commit;
        dbg_if.dret_commit   = v.stim.dret_commit;
        dbg_if.pipe_clear    = v.stim.pipe_clear;
        dbg_if.curr_priv     = v.stim.curr_priv;
        dbg_if.commit_pc     = v.stim.commit_pc;
        dbg_if.commit_npc    = v.stim.commit_npc;
        dbg_if.csr_wen       = v.stim.csr_wen;
        dbg_if.csr_addr      = v.stim.csr_addr;
        dbg_if.csr_wdata     = v.stim.csr_wdata;
        sb_q.push_back(v.exp);
        @(posedge clk);
        #1;
        check_output();
        step_no++;
    endtask

    // Hard stop in case something stalls the sequence
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nrst = 1'b0;
        // Reset state: everything low except restore_priv, CSR reads blocked
        apply_stimulus(mk(6'b000000, 2'd3, 32'h0, 32'h0, 1'b0, 12'h000, 32'h0, 5'b00000, 32'h0, 2'd3, 32'h0));
        apply_stimulus(mk(6'b000000, 2'd3, 32'h0, 32'h0, 1'b0, 12'h7B0, 32'h0, 5'b00000, 32'h0, 2'd3, 32'h0));
        nrst = 1'b1;

        // Halt request with commit, drain, read dcsr/dpc, resume request
        vec_q.push_back(mk(6'b101000, 2'd3, 32'h0FC, 32'h100, 1'b0, 12'h000, 32'h0, 5'b10000, 32'h0,   2'd3, 32'h0));
        vec_q.push_back(mk(6'b000001, 2'd3, 32'h0,   32'h0,   1'b0, 12'h7B0, 32'h0, 5'b11101, 32'h800, 2'd3, 32'h4000_00C3));
        vec_q.push_back(mk(6'b000000, 2'd3, 32'h0,   32'h0,   1'b0, 12'h7B1, 32'h0, 5'b11100, 32'h0,   2'd3, 32'h100));
        vec_q.push_back(mk(6'b100000, 2'd3, 32'h0,   32'h0,   1'b0, 12'h7B1, 32'h0, 5'b11100, 32'h0,   2'd3, 32'h100));
        vec_q.push_back(mk(6'b010000, 2'd3, 32'h0,   32'h0,   1'b0, 12'h000, 32'h0, 5'b01011, 32'h100, 2'd3, 32'h0));
        vec_q.push_back(mk(6'b000000, 2'd3, 32'h0,   32'h0,   1'b0, 12'h000, 32'h0, 5'b00000, 32'h0,   2'd3, 32'h0));
        // Halt request without commit stays pending; enable ebreakm; dret exit
        vec_q.push_back(mk(6'b100000, 2'd3, 32'h0,   32'h0,   1'b0, 12'h000, 32'h0, 5'b00000, 32'h0,   2'd3, 32'h0));
        vec_q.push_back(mk(6'b001000, 2'd0, 32'h1EC, 32'h1F0, 1'b0, 12'h000, 32'h0, 5'b10000, 32'h0,   2'd3, 32'h0));
        vec_q.push_back(mk(6'b000001, 2'd0, 32'h0,   32'h0,   1'b0, 12'h7B0, 32'h0, 5'b11101, 32'h800, 2'd3, 32'h4000_00C0));
        vec_q.push_back(mk(6'b000000, 2'd0, 32'h0,   32'h0,   1'b1, 12'h7B0, 32'hFFFF_FFFB, 5'b11100, 32'h0, 2'd3, 32'h4000_80C3));
        vec_q.push_back(mk(6'b000010, 2'd0, 32'h0,   32'h0,   1'b0, 12'h000, 32'h0, 5'b01011, 32'h1F0, 2'd3, 32'h0));
        vec_q.push_back(mk(6'b000000, 2'd3, 32'h0,   32'h0,   1'b0, 12'h000, 32'h0, 5'b00000, 32'h0,   2'd3, 32'h0));
        // M-mode ebreak beats a simultaneous halt request; ebreak while halted
        vec_q.push_back(mk(6'b101100, 2'd3, 32'h204, 32'h208, 1'b0, 12'h000, 32'h0, 5'b10000, 32'h0,   2'd3, 32'h0));
        vec_q.push_back(mk(6'b000001, 2'd3, 32'h0,   32'h0,   1'b0, 12'h7B0, 32'h0, 5'b11101, 32'h800, 2'd3, 32'h4000_8043));
        vec_q.push_back(mk(6'b000000, 2'd3, 32'h0,   32'h0,   1'b0, 12'h7B1, 32'h0, 5'b11100, 32'h0,   2'd3, 32'h204));
        vec_q.push_back(mk(6'b000100, 2'd3, 32'h990, 32'h994, 1'b0, 12'h7B1, 32'h0, 5'b11101, 32'h800, 2'd3, 32'h204));
        vec_q.push_back(mk(6'b000000, 2'd3, 32'h0,   32'h0,   1'b0, 12'h7B0, 32'h0, 5'b11100, 32'h0,   2'd3, 32'h4000_8043));
        vec_q.push_back(mk(6'b010010, 2'd3, 32'h0,   32'h0,   1'b0, 12'h000, 32'h0, 5'b01011, 32'h204, 2'd3, 32'h0));
        vec_q.push_back(mk(6'b000000, 2'd3, 32'h0,   32'h0,   1'b0, 12'h000, 32'h0, 5'b00000, 32'h0,   2'd3, 32'h0));
        // ebreak outside M-mode is not a debug entry
        vec_q.push_back(mk(6'b001100, 2'd0, 32'h300, 32'h304, 1'b0, 12'h000, 32'h0, 5'b00000, 32'h0,   2'd3, 32'h0));
        // dpc write outside debug mode is dropped; inside it is honoured
        vec_q.push_back(mk(6'b000000, 2'd3, 32'h0,   32'h0,   1'b1, 12'h7B1, 32'h403, 5'b00000, 32'h0,  2'd3, 32'h0));
        vec_q.push_back(mk(6'b101000, 2'd3, 32'h4FC, 32'h500, 1'b0, 12'h000, 32'h0, 5'b10000, 32'h0,   2'd3, 32'h0));
        vec_q.push_back(mk(6'b000000, 2'd3, 32'h0,   32'h0,   1'b0, 12'h000, 32'h0, 5'b10000, 32'h0,   2'd3, 32'h0));
        vec_q.push_back(mk(6'b000001, 2'd3, 32'h0,   32'h0,   1'b0, 12'h7B1, 32'h0, 5'b11101, 32'h800, 2'd3, 32'h500));
        vec_q.push_back(mk(6'b000000, 2'd3, 32'h0,   32'h0,   1'b1, 12'h7B1, 32'h403, 5'b11100, 32'h0,  2'd3, 32'h400));
        vec_q.push_back(mk(6'b000000, 2'd3, 32'h0,   32'h0,   1'b1, 12'h7B0, 32'h8005, 5'b11100, 32'h0, 2'd3, 32'h4000_80C5));
        vec_q.push_back(mk(6'b010000, 2'd3, 32'h0,   32'h0,   1'b0, 12'h000, 32'h0, 5'b01011, 32'h400, 2'd1, 32'h0));
        vec_q.push_back(mk(6'b000000, 2'd3, 32'h0,   32'h0,   1'b0, 12'h000, 32'h0, 5'b00000, 32'h0,   2'd1, 32'h0));
        // Single step: one retired instruction re-halts with cause 4
        vec_q.push_back(mk(6'b000000, 2'd1, 32'h0,   32'h0,   1'b0, 12'h000, 32'h0, 5'b00000, 32'h0,   2'd1, 32'h0));
        vec_q.push_back(mk(6'b001000, 2'd1, 32'h304, 32'h308, 1'b0, 12'h000, 32'h0, 5'b10000, 32'h0,   2'd1, 32'h0));
        vec_q.push_back(mk(6'b000001, 2'd1, 32'h0,   32'h0,   1'b0, 12'h7B0, 32'h0, 5'b11101, 32'h800, 2'd1, 32'h4000_8105));
        vec_q.push_back(mk(6'b001000, 2'd1, 32'h0,   32'h0,   1'b0, 12'h7B1, 32'h0, 5'b11100, 32'h0,   2'd1, 32'h308));
        vec_q.push_back(mk(6'b000000, 2'd1, 32'h0,   32'h0,   1'b1, 12'h7B0, 32'h8000, 5'b11100, 32'h0, 2'd1, 32'h4000_8100));
        vec_q.push_back(mk(6'b010000, 2'd1, 32'h0,   32'h0,   1'b0, 12'h000, 32'h0, 5'b01011, 32'h308, 2'd0, 32'h0));
        vec_q.push_back(mk(6'b000000, 2'd0, 32'h0,   32'h0,   1'b0, 12'h000, 32'h0, 5'b00000, 32'h0,   2'd0, 32'h0));
        vec_q.push_back(mk(6'b001000, 2'd3, 32'h408, 32'h40C, 1'b0, 12'h000, 32'h0, 5'b00000, 32'h0,   2'd0, 32'h0));

        for (int i = 0; i < vec_q.size(); i++) begin
            apply_stimulus(vec_q[i]);
        end

        // Reset in the middle of a drain aborts without a redirect pulse
        apply_stimulus(mk(6'b101000, 2'd3, 32'h5FC, 32'h600, 1'b0, 12'h000, 32'h0, 5'b10000, 32'h0, 2'd0, 32'h0));
        nrst = 1'b0;
        apply_stimulus(mk(6'b000001, 2'd3, 32'h0, 32'h0, 1'b0, 12'h000, 32'h0, 5'b00000, 32'h0, 2'd3, 32'h0));
        nrst = 1'b1;
        apply_stimulus(mk(6'b000000, 2'd3, 32'h0, 32'h0, 1'b0, 12'h000, 32'h0, 5'b00000, 32'h0, 2'd3, 32'h0));
        // dcsr must be back to its reset contents (ebreakm cleared)
        apply_stimulus(mk(6'b101000, 2'd3, 32'h5FC, 32'h600, 1'b0, 12'h000, 32'h0, 5'b10000, 32'h0, 2'd3, 32'h0));
        apply_stimulus(mk(6'b000001, 2'd3, 32'h0, 32'h0, 1'b0, 12'h7B0, 32'h0, 5'b11101, 32'h800, 2'd3, 32'h4000_00C3));
        apply_stimulus(mk(6'b010000, 2'd3, 32'h0, 32'h0, 1'b0, 12'h000, 32'h0, 5'b01011, 32'h600, 2'd3, 32'h0));
        apply_stimulus(mk(6'b000000, 2'd3, 32'h0, 32'h0, 1'b0, 12'h000, 32'h0, 5'b00000, 32'h0, 2'd3, 32'h0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/priv_1_12_debug_mode_ctrl.md
PRIV_1_12_DEBUG_MODE_CTRL -- requirements
Module: priv_1_12_debug_mode_ctrl

Interface
REQ-001 SHALL have parameter DEBUG_ENTRY_ADDR, default 32'h0000_0800, debug ROM entry PC.
REQ-002 SHALL have ports: CLK  in  1  clock, rising edge; nRST  in  1  reset, synchronous and active-low.
REQ-003 SHALL have ports: haltreq  in  1  halt request from debug module; resumereq  in  1  resume request from debug module.
REQ-004 SHALL have ports: insn_commit  in  1  instruction retired this cycle; ebreak_commit  in  1  ebreak reached commit; dret_commit  in  1  dret reached commit.
REQ-005 SHALL have ports: commit_pc  in  32  PC at commit; commit_npc  in  32  next sequential/target PC; pipe_clear  in  1  pipeline drained.
REQ-006 SHALL have ports: curr_priv  in  2  current privilege; csr_wen  in  1; csr_addr  in  12; csr_wdata  in  32.
REQ-007 SHALL have ports: csr_rdata  out  32; halt_pipe  out  1  freeze/flush request; dmode  out  1  debug mode active (feeds the interrupt/exception handler's dmode input).
REQ-008 SHALL have ports: halted  out  1; resumeack  out  1  one-cycle pulse; redirect_valid  out  1  one-cycle pulse; redirect_pc  out  32; restore_priv  out  2  valid with redirect on resume.

Function
REQ-009 SHALL implement FSM states RUN, DRAIN, HALTED, RESUME.
REQ-010 In RUN, entry trigger priority SHALL be: ebreak_commit with dcsr.ebreakm=1 and curr_priv=M (cause 1, dpc<=commit_pc), then haltreq with insn_commit=1 (cause 3, dpc<=commit_npc), then step_armed with insn_commit=1 (cause 4, dpc<=commit_npc).
REQ-011 On trigger, dcsr.cause, dpc, dcsr.prv<=curr_priv SHALL latch in the same edge; state SHALL go RUN->DRAIN.
REQ-012 haltreq with insn_commit=0 SHALL be held pending (not lost) until an insn_commit cycle.
REQ-013 halt_pipe SHALL be 1 in DRAIN and HALTED, 0 otherwise.
REQ-014 DRAIN->HALTED SHALL occur on pipe_clear=1; that cycle redirect_valid=1, redirect_pc=DEBUG_ENTRY_ADDR.
REQ-015 dmode and halted SHALL be 1 from first HALTED cycle through the RESUME cycle (dmode) / HALTED only (halted).
REQ-016 In HALTED, dret_commit or resumereq SHALL move to RESUME; dret wins if both; haltreq ignored.
REQ-017 In HALTED, ebreak_commit SHALL pulse redirect to DEBUG_ENTRY_ADDR without changing dpc, cause or state.
REQ-018 RESUME SHALL last one cycle: redirect_valid=1, redirect_pc=dpc, restore_priv=dcsr.prv, resumeack=1; next state RUN.
REQ-019 step_armed SHALL set on leaving RESUME if dcsr.step=1, and clear on entering DRAIN; insn_commit in DRAIN/HALTED SHALL not count.
REQ-020 dcsr at 12'h7B0, dpc at 12'h7B1: reads/writes SHALL be honored only when dmode=1; otherwise writes ignored, csr_rdata=0; csr_rdata=0 for other addresses.
REQ-021 dcsr layout: [31:28] xdebugver=4 (RO), [15] ebreakm, [8:6] cause (RO), [2] step, [1:0] prv; all other bits read 0.
REQ-022 dpc writes SHALL force bits [1:0] to 0.
REQ-023 CSR write and latching in the same cycle cannot coexist (writes only in dmode); a write to dcsr.prv in HALTED SHALL be used by the following RESUME.

Reset
REQ-024 On nRST=0 at a rising edge: state=RUN, dcsr=32'h4000_0003, dpc=0, step_armed=0, pending halt=0.
REQ-025 During/after reset all outputs SHALL be 0 except restore_priv=2'b11 and csr_rdata=0; reset mid-DRAIN/HALTED SHALL abort to RUN without redirect.

Structure
REQ-026 Package debug_types_1_12_pkg SHALL hold dbg_state_t, dbg_cause_t (EBREAK=1, HALTREQ=3, STEP=4), dcsr_t packed struct, DCSR_ADDR, DPC_ADDR.
REQ-027 Single module, no sub-module; all outputs except csr_rdata registered-state-derived (no input-to-output combinational path except CSR read mux).

Verification
REQ-028 haltreq=1, insn_commit=1, commit_npc=0x100 -> DRAIN; pipe_clear next -> redirect_pc=0x800, dmode=1, dcsr.cause=3, dpc=0x100.
REQ-029 dcsr.ebreakm=1, curr_priv=M, ebreak_commit, commit_pc=0x204 -> cause=1, dpc=0x204; dret_commit in HALTED -> redirect_pc=0x204, resumeack=1, dmode=0.
REQ-030 dcsr.step=1, resume, then one insn_commit with commit_npc=0x308 -> re-halt, cause=4, dpc=0x308.
REQ-031 csr write 0x7B1=0x403 while RUN -> ignored; in HALTED -> dpc=0x400; resume redirect_pc=0x400.
REQ-032 nRST=0 asserted during DRAIN -> next cycle state RUN, halt_pipe=0, dcsr=0x4000_0003, no redirect pulse.
